wb_regfile: RTL and testbench
=============================

Name: wb_regfile

Overview:
- Writeback-side consumer of the MEM/WB pipeline register: the 32x32 MIPS register file that commits the writeback triple (reg-write enable, data, destination).
- Provides two combinational read ports to the decode stage, with same-cycle write-through bypass.
- Holds a per-register pending-write scoreboard, set on decode issue and cleared on writeback, which produces operand hazard flags for decode stalling.
- Sits between the MEM/WB register (write side) and the ID stage (read and issue side).

Parameters:
- PEND_W, 2, width of each per-register pending counter; maximum in-flight writes per register is 2^PEND_W-1.
- CNT_W, 32, width of the committed-write counter.

Ports:
- clk  input  1  system clock; all state updates on rising edge.
- rst_n  input  1  asynchronous active-low reset.
- wb_reg_write  input  1  writeback enable from MEM/WB.
- wb_write_data  input  32  writeback data.
- wb_write_dest  input  5  writeback destination register.
- rs_addr  input  5  read port A address.
- rt_addr  input  5  read port B address.
- rs_data  output  32  read port A data.
- rt_data  output  32  read port B data.
- issue_valid  input  1  decode issues an instruction that will write issue_dest.
- issue_dest  input  5  destination of the issued instruction.
- rs_hazard  output  1  rs operand still has an outstanding write; decode must stall.
- rt_hazard  output  1  rt operand still has an outstanding write; decode must stall.
- issue_full  output  1  pending counter of issue_dest is at max and is not retiring this cycle.
- overflow_err  output  1  sticky: an issue was accepted while full.
- underflow_err  output  1  sticky: a writeback arrived with pending count 0.
- commit_count  output  CNT_W  number of committed writes to registers other than $0.

Behaviour:
- Reset (rst_n low, asynchronous): all 32 registers, all pending counters, overflow_err, underflow_err and commit_count clear to 0.
- Reset dominates clk.
- Outputs while in reset:
  - rs_data and rt_data read 0.
  - rs_hazard, rt_hazard and issue_full are 0.
- Reset asserted mid-stream discards all pending state; nothing is committed on the reset edge.
- Write: on posedge clk with wb_reg_write=1 and wb_write_dest!=0, reg[wb_write_dest] <= wb_write_data and commit_count increments by 1.
  - commit_count wraps modulo 2^CNT_W.
  - Writes to $0 are dropped and do not count; $0 always reads 0.
- Read, combinational, zero latency:
  - addr==0 -> 0.
  - Else if wb_reg_write=1 and wb_write_dest==addr -> wb_write_data (write-through bypass).
  - Else -> reg[addr].
  - Both ports are independent and may use the same address.
- Scoreboard, one counter cnt[r] per register r = 1..31; r = 0 is never tracked.
  - inc = issue_valid and issue_dest==r and issue_dest!=0.
  - dec = wb_reg_write and wb_write_dest==r and r!=0.
  - inc only: cnt+1. If cnt was already at max, cnt holds at max and overflow_err <= 1.
  - dec only: cnt-1. If cnt was 0, cnt holds 0, underflow_err <= 1, and the data write still occurs.
  - inc and dec together: cnt unchanged, no error.
- issue_full = issue_valid and issue_dest!=0 and cnt[issue_dest]==max and not dec for that register.
- Hazard (combinational): rs_hazard = rs_addr!=0 and (cnt[rs_addr] - dec_match) != 0, where dec_match = 1 when a writeback to rs_addr occurs this cycle.
  - The retiring write is covered by the bypass, so the last outstanding write does not raise a hazard.
  - rt_hazard is identical using rt_addr.
- Issue does not affect hazards in the same cycle; the incremented count is visible from the next cycle.
- Error flags are sticky until reset.

Test Plan:
- Reset then read: rst_n=0 mid-simulation (not clock-aligned) -> all reads 0, hazards 0, commit_count=0; after release, reading r5 gives 0.
- Write/read: write r5=0xDEADBEEF -> next cycle rs_data=0xDEADBEEF, commit_count=1. Write r0=0x12345678 -> rs_addr=0 reads 0, commit_count still 1.
- Bypass: in the same cycle wb writes r7=0xA5A5A5A5 while rs_addr=rt_addr=7 -> both ports show 0xA5A5A5A5 combinationally, before the edge.
- Scoreboard:
  - Issue r9 twice -> cnt=2, rs_hazard=1 for rs_addr=9.
  - First writeback to r9 -> rs_hazard=1 during that cycle.
  - Second writeback -> rs_hazard=0 in the retiring cycle, data bypassed.
- Simultaneous issue and writeback to r3 with cnt=1 -> cnt stays 1, no error flags.
- Boundaries:
  - Three issues to r4, then a fourth -> issue_full=1; accepting it sets overflow_err=1 and cnt stays 3.
  - Writeback to r6 with cnt=0 -> underflow_err=1 and r6 still written.
  - Reset clears both flags.

Source files
------------

// File: rtl/wb_regfile.sv
// Writeback-side MIPS register file: 32x32 storage with write-through read ports,
// plus a per-register pending-write scoreboard that drives decode stall flags.
module wb_regfile #(
    parameter int PEND_W = 2,
    parameter int CNT_W  = 32
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              wb_reg_write,
    input  logic [31:0]       wb_write_data,
    input  logic [4:0]        wb_write_dest,
    input  logic [4:0]        rs_addr,
    input  logic [4:0]        rt_addr,
    output logic [31:0]       rs_data,
    output logic [31:0]       rt_data,
    input  logic              issue_valid,
    input  logic [4:0]        issue_dest,
    output logic              rs_hazard,
    output logic              rt_hazard,
    output logic              issue_full,
    output logic              overflow_err,
    output logic              underflow_err,
    output logic [CNT_W-1:0]  commit_count
);

    localparam logic [PEND_W-1:0] PEND_MAX = {PEND_W{1'b1}};

    logic [31:0]       regs [32];
    logic [PEND_W-1:0] cnt  [32];

    logic              wb_we;
    logic              inc_any;
    logic              same_reg;
    logic [PEND_W-1:0] issue_cnt;
    logic [PEND_W-1:0] wb_cnt;

    // Entry 0 of both arrays is never written, so $0 stays 0 and is never tracked.
    assign wb_we     = wb_reg_write && (wb_write_dest != 5'd0);
    assign inc_any   = issue_valid && (issue_dest != 5'd0);
    assign same_reg  = inc_any && wb_we && (issue_dest == wb_write_dest);
    assign issue_cnt = cnt[issue_dest];
    assign wb_cnt    = cnt[wb_write_dest];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < 32; i++) begin
                regs[i] <= '0;
                cnt[i]  <= '0;
            end
            overflow_err  <= 1'b0;
            underflow_err <= 1'b0;
            commit_count  <= '0;
        end else begin
            if (wb_we) begin
                regs[wb_write_dest] <= wb_write_data;
                commit_count        <= commit_count + CNT_W'(1);
            end
            // An issue and a retire to the same register cancel out.
            if (!same_reg) begin
                if (inc_any) begin
                    if (issue_cnt == PEND_MAX) begin
                        overflow_err <= 1'b1;
                    end else begin
                        cnt[issue_dest] <= issue_cnt + PEND_W'(1);
                    end
                end
                if (wb_we) begin
                    if (wb_cnt == '0) begin
                        underflow_err <= 1'b1;
                    end else begin
                        cnt[wb_write_dest] <= wb_cnt - PEND_W'(1);
                    end
                end
            end
        end
    end

    logic              dec_rs;
    logic              dec_rt;
    logic [PEND_W-1:0] rs_cnt;
    logic [PEND_W-1:0] rt_cnt;

    assign dec_rs = wb_we && (wb_write_dest == rs_addr);
    assign dec_rt = wb_we && (wb_write_dest == rt_addr);
    assign rs_cnt = cnt[rs_addr];
    assign rt_cnt = cnt[rt_addr];

    // Reads and flags are forced quiet while reset is held, including the bypass path.
    always_comb begin
        rs_data = '0;
        rt_data = '0;
        if (rst_n && (rs_addr != 5'd0)) begin
            rs_data = dec_rs ? wb_write_data : regs[rs_addr];
        end
        if (rst_n && (rt_addr != 5'd0)) begin
            rt_data = dec_rt ? wb_write_data : regs[rt_addr];
        end
    end

    // A write retiring this cycle is covered by the bypass, so it does not stall.
    assign rs_hazard  = rst_n && (rs_addr != 5'd0) && ((rs_cnt - PEND_W'(dec_rs)) != '0);
    assign rt_hazard  = rst_n && (rt_addr != 5'd0) && ((rt_cnt - PEND_W'(dec_rt)) != '0);
    assign issue_full = rst_n && inc_any && (issue_cnt == PEND_MAX) && !same_reg;

endmodule

// File: tb/tb_wb_regfile.sv
// Directed bench for wb_regfile: expected values are queued when stimulus is
// driven and popped when the corresponding DUT output is sampled.
module tb_wb_regfile;

    logic        clk;
    logic        rst_n;
    logic        wb_reg_write;
    logic [31:0] wb_write_data;
    logic [4:0]  wb_write_dest;
    logic [4:0]  rs_addr;
    logic [4:0]  rt_addr;
    logic [31:0] rs_data;
    logic [31:0] rt_data;
    logic        issue_valid;
    logic [4:0]  issue_dest;
    logic        rs_hazard;
    logic        rt_hazard;
    logic        issue_full;
    logic        overflow_err;
    logic        underflow_err;
    logic [31:0] commit_count;

    int          assert_count;
    int          fail_count;
    int          exp_commit;
    logic [31:0] exp_q [$];

    wb_regfile #(.PEND_W(2), .CNT_W(32)) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .wb_reg_write  (wb_reg_write),
        .wb_write_data (wb_write_data),
        .wb_write_dest (wb_write_dest),
        .rs_addr       (rs_addr),
        .rt_addr       (rt_addr),
        .rs_data       (rs_data),
        .rt_data       (rt_data),
        .issue_valid   (issue_valid),
        .issue_dest    (issue_dest),
        .rs_hazard     (rs_hazard),
        .rt_hazard     (rt_hazard),
        .issue_full    (issue_full),
        .overflow_err  (overflow_err),
        .underflow_err (underflow_err),
        .commit_count  (commit_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] timeout");
    end

    task automatic applyStimulus(input logic we, input logic [4:0] dest, input logic [31:0] data,
                                 input logic iv, input logic [4:0] idest,
                                 input logic [4:0] rs, input logic [4:0] rt);
        wb_reg_write  = we;
        wb_write_dest = dest;
        wb_write_data = data;
        issue_valid   = iv;
        issue_dest    = idest;
        rs_addr       = rs;
        rt_addr       = rt;
        if (we && dest != 5'd0 && rst_n) exp_commit++;
    endtask

    task automatic expectValue(input logic [31:0] v);
        exp_q.push_back(v);
    endtask

    task automatic checkOutput(input string tag, input logic [31:0] observed);
        logic [31:0] expected;
        assert_count++;
        if (exp_q.size() == 0) begin
            fail_count++;
            $error("[TB] FAIL %s: observed %h but scoreboard empty", tag, observed);
        end else begin
            expected = exp_q.pop_front();
            assert (observed === expected) else begin
                fail_count++;
                $error("[TB] FAIL %s: observed %h expected %h", tag, observed, expected);
            end
        end
    endtask

    // Lets the current inputs be sampled on the next rising edge, returns at the falling edge.
    task automatic cycle();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic idle(input logic [4:0] rs, input logic [4:0] rt);
        applyStimulus(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, rs, rt);
    endtask

    initial begin
        assert_count = 0;
        fail_count   = 0;
        exp_commit   = 0;
        rst_n        = 1'b0;
        applyStimulus(1'b1, 5'd5, 32'hCAFE0000, 1'b0, 5'd0, 5'd5, 5'd5);

        // Reset held with a writeback active: reads and flags stay quiet.
        @(negedge clk); #1;
        expectValue(32'h0); checkOutput("reset_rs_data", rs_data);
        expectValue(32'h0); checkOutput("reset_rt_data", rt_data);
        expectValue(32'h0); checkOutput("reset_rs_hazard", 32'(rs_hazard));
        expectValue(32'h0); checkOutput("reset_commit", commit_count);
        @(negedge clk);
        idle(5'd5, 5'd0);
        rst_n = 1'b1;
        #1;
        expectValue(32'h0); checkOutput("post_reset_r5", rs_data);

        // Write/read r5 (issued first so no underflow).
        applyStimulus(1'b0, 5'd0, 32'h0, 1'b1, 5'd5, 5'd5, 5'd0);
        cycle();
        applyStimulus(1'b1, 5'd5, 32'hDEADBEEF, 1'b0, 5'd0, 5'd5, 5'd0);
        cycle();
        idle(5'd5, 5'd0); #1;
        expectValue(32'hDEADBEEF); checkOutput("r5_read", rs_data);
        expectValue(32'(exp_commit)); checkOutput("commit_1", commit_count);

        // Write to $0 is dropped and not counted.
        applyStimulus(1'b1, 5'd0, 32'h12345678, 1'b0, 5'd0, 5'd0, 5'd0); #1;
        expectValue(32'h0); checkOutput("r0_bypass", rs_data);
        cycle();
        idle(5'd0, 5'd0); #1;
        expectValue(32'h0); checkOutput("r0_read", rs_data);
        expectValue(32'd1); checkOutput("commit_r0", commit_count);

        // Same-cycle bypass on both ports.
        applyStimulus(1'b0, 5'd0, 32'h0, 1'b1, 5'd7, 5'd0, 5'd0);
        cycle();
        applyStimulus(1'b1, 5'd7, 32'hA5A5A5A5, 1'b0, 5'd0, 5'd7, 5'd7); #1;
        expectValue(32'hA5A5A5A5); checkOutput("bypass_rs", rs_data);
        expectValue(32'hA5A5A5A5); checkOutput("bypass_rt", rt_data);
        expectValue(32'h0); checkOutput("bypass_no_hazard", 32'(rs_hazard));
        cycle();
        idle(5'd7, 5'd7); #1;
        expectValue(32'hA5A5A5A5); checkOutput("r7_stored", rt_data);

        // Two issues to r9, then two retires.
        applyStimulus(1'b0, 5'd0, 32'h0, 1'b1, 5'd9, 5'd9, 5'd0); #1;
        expectValue(32'h0); checkOutput("issue_same_cycle_hazard", 32'(rs_hazard));
        cycle();
        cycle();
        idle(5'd9, 5'd0); #1;
        expectValue(32'h1); checkOutput("r9_hazard_cnt2", 32'(rs_hazard));
        applyStimulus(1'b1, 5'd9, 32'h11111111, 1'b0, 5'd0, 5'd9, 5'd0); #1;
        expectValue(32'h1); checkOutput("r9_hazard_first_wb", 32'(rs_hazard));
        cycle();
        applyStimulus(1'b1, 5'd9, 32'h22222222, 1'b0, 5'd0, 5'd9, 5'd0); #1;
        expectValue(32'h0); checkOutput("r9_hazard_last_wb", 32'(rs_hazard));
        expectValue(32'h22222222); checkOutput("r9_bypass", rs_data);
        cycle();
        idle(5'd9, 5'd0); #1;
        expectValue(32'h0); checkOutput("r9_hazard_clear", 32'(rs_hazard));

        // Simultaneous issue and retire on r3 with one pending.
        applyStimulus(1'b0, 5'd0, 32'h0, 1'b1, 5'd3, 5'd0, 5'd3);
        cycle();
        applyStimulus(1'b1, 5'd3, 32'h33333333, 1'b1, 5'd3, 5'd0, 5'd3); #1;
        expectValue(32'h0); checkOutput("r3_hazard_both", 32'(rt_hazard));
        cycle();
        idle(5'd0, 5'd3); #1;
        expectValue(32'h1); checkOutput("r3_cnt_held", 32'(rt_hazard));
        expectValue(32'h0); checkOutput("r3_no_overflow", 32'(overflow_err));
        expectValue(32'h0); checkOutput("r3_no_underflow", 32'(underflow_err));

        // Fill r4 to max, then overflow attempt.
        for (int i = 0; i < 3; i++) begin
            applyStimulus(1'b0, 5'd0, 32'h0, 1'b1, 5'd4, 5'd4, 5'd0); #1;
            expectValue(32'h0); checkOutput("r4_not_full", 32'(issue_full));
            cycle();
        end
        applyStimulus(1'b0, 5'd0, 32'h0, 1'b1, 5'd4, 5'd4, 5'd0); #1;
        expectValue(32'h1); checkOutput("r4_full", 32'(issue_full));
        cycle();
        idle(5'd4, 5'd0); #1;
        expectValue(32'h1); checkOutput("overflow_set", 32'(overflow_err));
        applyStimulus(1'b1, 5'd4, 32'h44440000, 1'b1, 5'd4, 5'd4, 5'd0); #1;
        expectValue(32'h0); checkOutput("r4_full_retiring", 32'(issue_full));
        cycle();
        for (int i = 0; i < 3; i++) begin
            applyStimulus(1'b1, 5'd4, 32'h44440001 + 32'(i), 1'b0, 5'd0, 5'd4, 5'd0); #1;
            expectValue((i == 2) ? 32'h0 : 32'h1); checkOutput("r4_drain_hazard", 32'(rs_hazard));
            cycle();
        end
        idle(5'd4, 5'd0); #1;
        expectValue(32'h0); checkOutput("r4_drained_no_underflow", 32'(underflow_err));
        expectValue(32'h44440003); checkOutput("r4_last_data", rs_data);

        // Underflow on r6.
        applyStimulus(1'b1, 5'd6, 32'h66666666, 1'b0, 5'd0, 5'd0, 5'd0);
        cycle();
        idle(5'd6, 5'd0); #1;
        expectValue(32'h1); checkOutput("underflow_set", 32'(underflow_err));
        expectValue(32'h66666666); checkOutput("r6_written", rs_data);
        expectValue(32'(exp_commit)); checkOutput("commit_total", commit_count);

        // Leave a pending write on r8, then reset asynchronously mid-cycle.
        applyStimulus(1'b0, 5'd0, 32'h0, 1'b1, 5'd8, 5'd0, 5'd0);
        cycle();
        applyStimulus(1'b1, 5'd6, 32'h77777777, 1'b1, 5'd4, 5'd6, 5'd8);
        #3 rst_n = 1'b0;
        #1;
        expectValue(32'h0); checkOutput("midreset_rs_data", rs_data);
        expectValue(32'h0); checkOutput("midreset_rt_hazard", 32'(rt_hazard));
        expectValue(32'h0); checkOutput("midreset_issue_full", 32'(issue_full));
        expectValue(32'h0); checkOutput("midreset_overflow", 32'(overflow_err));
        expectValue(32'h0); checkOutput("midreset_underflow", 32'(underflow_err));
        expectValue(32'h0); checkOutput("midreset_commit", commit_count);
        cycle();
        idle(5'd6, 5'd8);
        #2 rst_n = 1'b1;
        #1;
        expectValue(32'h0); checkOutput("after_reset_r6", rs_data);
        expectValue(32'h0); checkOutput("after_reset_r8_hazard", 32'(rt_hazard));
        cycle();
        idle(5'd5, 5'd0); #1;
        expectValue(32'h0); checkOutput("after_reset_r5", rs_data);
        expectValue(32'h0); checkOutput("after_reset_commit", commit_count);

        $display("End of test - %0d assertions evaluated, %0d failures", assert_count, fail_count);
        $finish;
    end

endmodule
